color_palette: RTL and testbench

Parametrised, pipelined pixel colour generator for the VGA path. It maps a colour index plus a mode bit to per-channel RGB, in either fixed grayscale or a run-time programmable palette. It adds a frame-timed "hit flash" brightness boost and forces blanking outside the active video region. It sits between the note/lane renderer and the VGA output registers.

---
 rtl/color_pkg.sv | 48 ++++
 rtl/color_palette_if.sv | 39 +++
 rtl/palette_regfile.sv | 39 +++
 rtl/color_palette.sv | 115 +++++++++++
 tb/tb_color_palette.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared constants and reset palette contents for color_palette
//
// Purpose: mode constants, BW decode codes, named palette indices and the
// function that yields the power-up RGB of each palette entry.
package color_pkg;

  typedef enum logic {
    BW      = 1'b0,
    COLORED = 1'b1
  } color_mode_e;

  // BW-mode colour codes
  localparam int BLACK = 0;
  localparam int WHITE = 1;
  localparam int GRAY  = 2;

  // Palette indices with a non-black reset value
  localparam int GREEN  = 0;
  localparam int RED    = 1;
  localparam int YELLOW = 2;
  localparam int BLUE   = 3;
  localparam int ORANGE = 4;

  // Returns {r,g,b} packed at cw bits per channel in the low 3*cw bits.
  // Orange green is 4'b1010 left-aligned in cw bits.
  function automatic logic [23:0] default_entry(input int idx, input int cw);
    int m;
    int o;
    int r;
    int g;
    int b;
    m = (1 << cw) - 1;
    o = 10 << (cw - 4);
    r = 0;
    g = 0;
    b = 0;
    case (idx)
      GREEN:  g = m;
      RED:    r = m;
      YELLOW: begin r = m; g = m; end
      BLUE:   b = m;
      ORANGE: begin r = m; g = o; end
      default: ;
    endcase
    return 24'((r << (2 * cw)) | (g << cw) | b);
  endfunction

endpackage

// File: rtl/color_palette_if.sv
// rtl/color_palette_if.sv - pixel, palette-write, flash and VGA output bundle
//
// Purpose: groups every color_palette signal except clk/rst_n.
// Ports (master = renderer side, slave = color_palette):
//   frame_start, pix_valid, color_mode, color[IW]   pixel stream in
//   wr_en, wr_addr[IW], wr_data[3*CW]               palette write port
//   flash_trig                                      flash start/restart
//   red, green, blue [CW], out_valid                registered VGA out
interface color_palette_if #(
  parameter int CW         = 4,
  parameter int NUM_COLORS = 8
);
  localparam int IW = $clog2(NUM_COLORS);

  logic            frame_start;
  logic            pix_valid;
  logic            color_mode;
  logic [IW-1:0]   color;
  logic            wr_en;
  logic [IW-1:0]   wr_addr;
  logic [3*CW-1:0] wr_data;
  logic            flash_trig;
  logic [CW-1:0]   red;
  logic [CW-1:0]   green;
  logic [CW-1:0]   blue;
  logic            out_valid;

  modport master (
    output frame_start, pix_valid, color_mode, color,
    output wr_en, wr_addr, wr_data, flash_trig,
    input  red, green, blue, out_valid
  );

  modport slave (
    input  frame_start, pix_valid, color_mode, color,
    input  wr_en, wr_addr, wr_data, flash_trig,
    output red, green, blue, out_valid
  );
endinterface

// File: rtl/palette_regfile.sv
// rtl/palette_regfile.sv - programmable colour palette storage
//
// Purpose: NUM_COLORS x 3*CW flop array, reset to the default palette.
// Ports:
//   clk, rst_n             pixel clock, async active-low reset
//   wr_en, wr_addr, wr_data  single write port, updates at the clock edge
//   rd_addr, rd_data        combinational read (returns pre-write contents)
module palette_regfile
  import color_pkg::*;
#(
  parameter  int CW         = 4,
  parameter  int NUM_COLORS = 8,
  localparam int IW         = $clog2(NUM_COLORS),
  localparam int DW         = 3 * CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [NUM_COLORS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        mem[i] <= DW'(default_entry(i, CW));
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/color_palette.sv
// rtl/color_palette.sv - two-stage pixel colour generator with hit flash
//
// Purpose: maps colour index + mode to RGB (BW decode or palette), adds the
// frame-timed flash boost with saturation and blanks outside active video.
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   bus          color_palette_if.slave (pixel in, palette write, flash, RGB out)
module color_palette
  import color_pkg::*;
#(
  parameter int CW           = 4,
  parameter int NUM_COLORS   = 8,
  parameter int FLASH_FRAMES = 8
) (
  input logic             clk,
  input logic             rst_n,
  color_palette_if.slave  bus
);

  localparam int IW = $clog2(NUM_COLORS);
  localparam int LW = $clog2(FLASH_FRAMES + 1);
  localparam int DW = 3 * CW;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] HALF = {1'b1, {(CW-1){1'b0}}};

  logic [DW-1:0] rd_data;
  logic [DW-1:0] bw_rgb;
  logic [DW-1:0] base_rgb;
  logic [DW-1:0] s1_rgb;
  logic          s1_valid;
  logic [LW-1:0] flash_level;
  logic [CW-1:0] red_q;
  logic [CW-1:0] green_q;
  logic [CW-1:0] blue_q;
  logic          valid_q;

  palette_regfile #(
    .CW        (CW),
    .NUM_COLORS(NUM_COLORS)
  ) u_palette (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_addr(bus.color),
    .rd_data(rd_data)
  );

  always_comb begin
    bw_rgb = {3{CMAX}};
    if (bus.color == IW'(BLACK)) begin
      bw_rgb = '0;
    end else if (bus.color == IW'(GRAY)) begin
      bw_rgb = {3{HALF}};
    end
    base_rgb = (bus.color_mode == COLORED) ? rd_data : bw_rgb;
  end

  // Stage 1: base colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_rgb   <= base_rgb;
      s1_valid <= bus.pix_valid;
    end
  end

  // Flash level: a trigger reloads even when frame_start coincides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_level <= '0;
    end else if (bus.flash_trig) begin
      flash_level <= LW'(FLASH_FRAMES);
    end else if (bus.frame_start && (flash_level != '0)) begin
      flash_level <= flash_level - 1'b1;
    end
  end

  // Add at CW+1 bits so the carry flags saturation
  function automatic logic [CW-1:0] boost(input logic [CW-1:0] c, input logic [LW-1:0] l);
    logic [CW:0] s;
    s = {1'b0, c} + (CW+1)'(l);
    return s[CW] ? CMAX : s[CW-1:0];
  endfunction

  // Stage 2: boost, blank, register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= s1_valid;
      if (s1_valid) begin
        red_q   <= boost(s1_rgb[3*CW-1:2*CW], flash_level);
        green_q <= boost(s1_rgb[2*CW-1:CW], flash_level);
        blue_q  <= boost(s1_rgb[CW-1:0], flash_level);
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_color_palette.sv
// tb/tb_color_palette.sv - scoreboard bench for color_palette (CW=4 and CW=8 instances)
module tb_color_palette;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    int due;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int pa[16][3];
  int pb[16][3];
  int la;
  int lb;

  color_palette_if #(.CW(4), .NUM_COLORS(8))  ifa ();
  color_palette_if #(.CW(8), .NUM_COLORS(16)) ifb ();

  color_palette #(.CW(4), .NUM_COLORS(8), .FLASH_FRAMES(8)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  color_palette #(.CW(8), .NUM_COLORS(16), .FLASH_FRAMES(8)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reset palette colours from the colour table: green, red, yellow, blue, orange
  function automatic int def_c(int cw, int idx, int ch);
    int m;
    m = (1 << cw) - 1;
    case (idx)
      0: return (ch == 1) ? m : 0;
      1: return (ch == 0) ? m : 0;
      2: return (ch < 2) ? m : 0;
      3: return (ch == 2) ? m : 0;
      4: return (ch == 0) ? m : ((ch == 1) ? (10 << (cw - 4)) : 0);
      default: return 0;
    endcase
  endfunction

  // Expected channel: BW rules or palette value, plus flash, clipped to max
  function automatic int chan(int cw, bit mode, int idx, int pal_c, int lvl);
    int m;
    int c;
    m = (1 << cw) - 1;
    if (mode) c = pal_c;
    else if (idx == 0) c = 0;
    else if (idx == 2) c = 1 << (cw - 1);
    else c = m;
    c = c + lvl;
    return (c > m) ? m : c;
  endfunction

  task automatic reset_models();
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 3; c++) begin
        pa[i][c] = def_c(4, i, c);
        pb[i][c] = def_c(8, i, c);
      end
    end
    la = 0;
    lb = 0;
    qa.delete();
    qb.delete();
  endtask

  // Issue the current inputs for one clock, predict outputs, clear strobes
  task automatic tick();
    exp_t e;
    int   ia;
    int   ib;
    int   oa[3];
    int   ob[3];
    ia = int'(ifa.color);
    ib = int'(ifb.color);
    for (int c = 0; c < 3; c++) begin
      oa[c] = pa[ia][c];
      ob[c] = pb[ib][c];
    end
    if (ifa.wr_en) begin
      pa[int'(ifa.wr_addr)][0] = int'(ifa.wr_data[11:8]);
      pa[int'(ifa.wr_addr)][1] = int'(ifa.wr_data[7:4]);
      pa[int'(ifa.wr_addr)][2] = int'(ifa.wr_data[3:0]);
    end
    if (ifb.wr_en) begin
      pb[int'(ifb.wr_addr)][0] = int'(ifb.wr_data[23:16]);
      pb[int'(ifb.wr_addr)][1] = int'(ifb.wr_data[15:8]);
      pb[int'(ifb.wr_addr)][2] = int'(ifb.wr_data[7:0]);
    end
    if (ifa.flash_trig) la = 8;
    else if (ifa.frame_start && la > 0) la = la - 1;
    if (ifb.flash_trig) lb = 8;
    else if (ifb.frame_start && lb > 0) lb = lb - 1;
    if (ifa.pix_valid) begin
      e.due = cyc + 2;
      e.r = chan(4, ifa.color_mode, ia, oa[0], la);
      e.g = chan(4, ifa.color_mode, ia, oa[1], la);
      e.b = chan(4, ifa.color_mode, ia, oa[2], la);
      qa.push_back(e);
    end
    if (ifb.pix_valid) begin
      e.due = cyc + 2;
      e.r = chan(8, ifb.color_mode, ib, ob[0], lb);
      e.g = chan(8, ifb.color_mode, ib, ob[1], lb);
      e.b = chan(8, ifb.color_mode, ib, ob[2], lb);
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    ifa.pix_valid = 0; ifa.wr_en = 0; ifa.flash_trig = 0; ifa.frame_start = 0;
    ifb.pix_valid = 0; ifb.wr_en = 0; ifb.flash_trig = 0; ifb.frame_start = 0;
  endtask

  task automatic pix_a(input bit mode, input int idx);
    ifa.pix_valid  = 1;
    ifa.color_mode = mode;
    ifa.color      = 3'(idx);
  endtask

  task automatic pix_b(input bit mode, input int idx);
    ifb.pix_valid  = 1;
    ifb.color_mode = mode;
    ifb.color      = 4'(idx);
  endtask

  // Monitors: in-order pops with latency check; idle cycles must be blank
  always @(negedge clk) begin
    exp_t e;
    bit   miss;
    if (rst_n) begin
      if (ifa.out_valid) begin
        if (qa.size() == 0) begin
          chk("a_extra_valid", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_latency", cyc, e.due);
          chk("a_rgb", {ifa.red, ifa.green, ifa.blue}, (e.r << 8) | (e.g << 4) | e.b);
        end
      end else begin
        chk("a_blank", {ifa.red, ifa.green, ifa.blue}, 0);
        miss = (qa.size() != 0) && (qa[0].due <= cyc);
        chk("a_missing_valid", miss, 0);
        if (miss) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   miss;
    if (rst_n) begin
      if (ifb.out_valid) begin
        if (qb.size() == 0) begin
          chk("b_extra_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_latency", cyc, e.due);
          chk("b_rgb", {ifb.red, ifb.green, ifb.blue}, (e.r << 16) | (e.g << 8) | e.b);
        end
      end else begin
        chk("b_blank", {ifb.red, ifb.green, ifb.blue}, 0);
        miss = (qb.size() != 0) && (qb[0].due <= cyc);
        chk("b_missing_valid", miss, 0);
        if (miss) void'(qb.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_out"}, {ifa.out_valid, ifa.red, ifa.green, ifa.blue}, 0);
    chk({tag, "_b_out"}, {ifb.out_valid, ifb.red, ifb.green, ifb.blue}, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1;
    ifa.pix_valid = 0; ifa.color_mode = 0; ifa.color = 0; ifa.wr_en = 0;
    ifa.wr_addr = 0; ifa.wr_data = 0; ifa.flash_trig = 0; ifa.frame_start = 0;
    ifb.pix_valid = 0; ifb.color_mode = 0; ifb.color = 0; ifb.wr_en = 0;
    ifb.wr_addr = 0; ifb.wr_data = 0; ifb.flash_trig = 0; ifb.frame_start = 0;
    reset_models();
    #1 rst_n = 0;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    // Coloured orange, then BW black/gray/white, blanking
    pix_a(1, 4); pix_b(1, 4); tick();
    pix_a(0, 0); pix_b(1, 15); tick();
    pix_a(0, 2); pix_b(0, 2); tick();
    pix_a(0, 5); pix_b(0, 0); tick();
    ifa.color_mode = 0; ifa.color = 5; tick();
    tick();

    // Read-before-write on entry 1, then the new value
    pix_a(1, 1); ifa.wr_en = 1; ifa.wr_addr = 1; ifa.wr_data = 12'h345;
    pix_b(1, 7); ifb.wr_en = 1; ifb.wr_addr = 7; ifb.wr_data = 24'h12F0AB;
    tick();
    pix_a(1, 1); pix_b(1, 7); tick();

    // Flash: trigger, decay over frames, floor at zero
    ifa.flash_trig = 1; ifb.flash_trig = 1; tick();
    pix_a(1, 3); pix_b(1, 3); tick();
    for (int i = 0; i < 3; i++) begin
      ifa.frame_start = 1; ifb.frame_start = 1; tick();
    end
    pix_a(1, 3); pix_b(0, 2); tick();
    for (int i = 0; i < 8; i++) begin
      ifa.frame_start = 1; pix_a(1, 3); tick();
    end
    pix_a(1, 3); tick();

    // Trigger coincident with frame_start at level 2
    ifa.flash_trig = 1; tick();
    for (int i = 0; i < 6; i++) begin
      ifa.frame_start = 1; tick();
    end
    pix_a(1, 3); tick();
    ifa.flash_trig = 1; ifa.frame_start = 1; pix_a(1, 3); tick();
    pix_a(0, 0); tick();

    // Asynchronous reset mid-flash, palette restored
    ifa.flash_trig = 1; pix_a(1, 1); pix_b(1, 7); tick();
    pix_a(1, 0); tick();
    #2 rst_n = 0;
    #1 check_reset_outputs("mid");
    reset_models();
    @(posedge clk);
    #1 rst_n = 1;
    pix_a(1, 1); pix_b(1, 7); tick();
    pix_a(1, 0); pix_b(1, 4); tick();

    // Randomised traffic on both instances
    for (int i = 0; i < 800; i++) begin
      ifa.pix_valid   = ($urandom_range(0, 3) != 0);
      ifa.color_mode  = 1'($urandom);
      ifa.color       = 3'($urandom);
      ifa.wr_en       = ($urandom_range(0, 7) == 0);
      ifa.wr_addr     = 3'($urandom);
      ifa.wr_data     = 12'($urandom);
      ifa.flash_trig  = ($urandom_range(0, 40) == 0);
      ifa.frame_start = ($urandom_range(0, 6) == 0);
      ifb.pix_valid   = ($urandom_range(0, 3) != 0);
      ifb.color_mode  = 1'($urandom);
      ifb.color       = 4'($urandom);
      ifb.wr_en       = ($urandom_range(0, 7) == 0);
      ifb.wr_addr     = 4'($urandom);
      ifb.wr_data     = 24'($urandom);
      ifb.flash_trig  = ($urandom_range(0, 40) == 0);
      ifb.frame_start = ($urandom_range(0, 6) == 0);
      tick();
    end

    for (int i = 0; i < 4; i++) tick();
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
